pool_window_fetch: RTL
======================

Name: pool_window_fetch

Overview:
- Upstream feeder for the 4x4-window max-pool stage.
- Reads a single-channel 8-bit image stored row-major in a single-port BRAM (1-cycle read latency).
- Assembles 4x4 pixel windows at stride 2 and presents each as a 128-bit packed word on a valid/ready handshake.
- One start pulse walks every window position in raster order, then signals done.

Parameters:
- IMG_W, 8, image width in pixels; must be >=4 and even.
- IMG_H, 8, image height in pixels; must be >=4 and even.
- ADDR_W, 6, BRAM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.
- DATA_W, 8, pixel width; fixed at 8, since the downstream stage requires it.

Ports:
- clk, input, 1, single clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle request to process the whole image.
- busy, output, 1, high from start acceptance until done.
- done, output, 1, one-cycle pulse after the last window handshake.
- bram_en, output, 1, BRAM read enable.
- bram_addr, output, ADDR_W, BRAM read address.
- bram_dout, input, DATA_W, BRAM read data, valid 1 cycle after bram_en.
- win_data, output, 128, packed window; pixel (i,j) at bits [(4*i+j)*8 +: 8], i = row 0..3, j = col 0..3.
- win_valid, output, 1, win_data holds a complete window.
- win_ready, input, 1, downstream accepts the window.
- win_row, output, 8, image row of the window's top-left pixel.
- win_col, output, 8, image column of the window's top-left pixel.

Behaviour:
- Reset (async assert, sync release): state IDLE; busy, done, bram_en, win_valid = 0; bram_addr, win_data, win_row, win_col = 0; row/col/element counters = 0.
- IDLE:
  - start=1 at an edge: latch origin (0,0), busy=1, go to FETCH.
  - start while busy is ignored.
- FETCH:
  - 16 consecutive cycles, bram_en=1, element k=0..15 in order.
  - bram_addr = (win_row+i)*IMG_W + (win_col+j), with i=k>>2 and j=k&3.
  - Address arithmetic uses ADDR_W+1 bits internally and is truncated to ADDR_W.
- CAPTURE:
  - bram_dout for element k is written into its win_data slot on the edge after its address was issued.
  - A 1-cycle CAPTURE state after FETCH (bram_en=0) absorbs the last read.
- PRESENT:
  - win_valid is asserted after the 17th rising edge following the start-sampling edge.
  - While win_valid=1 and win_ready=0, win_data, win_row and win_col are held stable.
  - Handshake occurs on win_valid&win_ready at an edge; win_valid drops the next cycle.
- ADVANCE, on each handshake:
  - win_col += 2.
  - If win_col+2 > IMG_W-4: win_col=0 and win_row += 2.
  - If win_row+2 > IMG_H-4: last window, go to DONE; otherwise return to FETCH.
- Window count: ((IMG_H-4)/2+1) * ((IMG_W-4)/2+1); 9 for 8x8.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- win_ready high while win_valid=0 has no effect.
- No prefetch: the next FETCH starts only after the handshake.
- Throughput is one window per 18 cycles with win_ready tied high.
- Reset mid-operation: everything returns to reset values immediately; a partial window is discarded.

Optional Feature:
- Macro: STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt [15:0], counting cycles with win_valid=1 and win_ready=0.
  - Saturates at 16'hFFFF.
  - Cleared on reset and on start acceptance.
  - Holds its value after done.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pool_pkg:
  - PIX_W=8, WIN_DIM=4, WIN_STRIDE=2, WIN_BITS=128, OUT_BITS=32.
  - FSM state enum: IDLE, FETCH, CAPTURE, PRESENT, DONE.
- Sub-module pool_addr_gen:
  - Owns the row/col/element counters and address computation.
  - Exposes issue, advance, last_elem and last_win.
- FSM and window register live in the top.

Test Plan:
- 8x8 image, BRAM[a]=a, win_ready=1, one start:
  - First window (0,0) has win_data byte (4i+j) = 8i+j, so byte 5 = 9 and byte 15 = 27.
  - 9 windows appear in raster order (0,0),(0,2),(0,4),(2,0)...(4,4).
  - done pulses once.
- Same image, window (0,2):
  - byte0 = 2, byte15 = 29.
  - win_valid rises exactly 17 edges after start is sampled.
- Backpressure: hold win_ready=0 for 5 cycles on window 1:
  - win_data, win_row and win_col stay stable.
  - No bram_en during the stall.
  - stall_cnt=5 with STALL_CNT_EN.
- Pulse start again while busy:
  - Ignored; still exactly 9 windows and 1 done.
- Assert rst_n=0 during FETCH of window 3:
  - All outputs go to 0 asynchronously.
  - A new start after release produces window (0,0) again with correct data.
- IMG_W=IMG_H=4:
  - Exactly 1 window, data = BRAM[0..15] in order.
  - done follows its handshake by 1 cycle.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared constants and FSM state type for the max-pool window fetch path.
package pool_pkg;

    localparam int PIX_W      = 8;
    localparam int WIN_DIM    = 4;
    localparam int WIN_STRIDE = 2;
    localparam int WIN_BITS   = 128;
    localparam int OUT_BITS   = 32;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPTURE,
        PRESENT,
        DONE
    } state_e;

endpackage

// File: rtl/pool_addr_gen.sv
// Window origin / element counters and BRAM address generation for the
// 4x4 stride-2 window walk.
module pool_addr_gen
    import pool_pkg::*;
#(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              issue_i,
    input  logic              advance_i,
    output logic [3:0]        elem_o,
    output logic [7:0]        row_o,
    output logic [7:0]        col_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_elem_o,
    output logic              last_win_o
);

    localparam int AW1 = ADDR_W + 1;

    logic [7:0]     row_q, row_d;
    logic [7:0]     col_q, col_d;
    logic [3:0]     elem_q, elem_d;
    logic           col_wrap, row_last;
    logic [AW1-1:0] row_ext, addr_full;

    assign col_wrap    = (int'(col_q) + WIN_STRIDE) > (IMG_W - WIN_DIM);
    assign row_last    = (int'(row_q) + WIN_STRIDE) > (IMG_H - WIN_DIM);
    assign last_win_o  = col_wrap && row_last;
    assign last_elem_o = (elem_q == 4'd15);

    assign row_ext   = AW1'(row_q) + AW1'(elem_q[3:2]);
    assign addr_full = row_ext * AW1'(IMG_W) + AW1'(col_q) + AW1'(elem_q[1:0]);
    assign addr_o    = ADDR_W'(addr_full);

    always_comb begin
        row_d  = row_q;
        col_d  = col_q;
        elem_d = elem_q;
        if (clear_i) begin
            row_d  = '0;
            col_d  = '0;
            elem_d = '0;
        end else begin
            if (issue_i) begin
                elem_d = elem_q + 4'd1;
            end
            if (advance_i) begin
                // Final window wraps the origin back to (0,0) for the next frame.
                if (last_win_o) begin
                    row_d = '0;
                    col_d = '0;
                end else if (col_wrap) begin
                    col_d = '0;
                    row_d = row_q + 8'(WIN_STRIDE);
                end else begin
                    col_d = col_q + 8'(WIN_STRIDE);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q  <= '0;
            col_q  <= '0;
            elem_q <= '0;
        end else begin
            row_q  <= row_d;
            col_q  <= col_d;
            elem_q <= elem_d;
        end
    end

    assign elem_o = elem_q;
    assign row_o  = row_q;
    assign col_o  = col_q;

endmodule

// File: rtl/pool_window_fetch.sv
// Fetches 4x4 stride-2 pixel windows from a 1-cycle-latency BRAM and presents
// them on a valid/ready port. Define STALL_CNT_EN to add the stall_cnt output.
module pool_window_fetch
    import pool_pkg::*;
#(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                bram_en,
    output logic [ADDR_W-1:0]   bram_addr,
    input  logic [DATA_W-1:0]   bram_dout,
    output logic [WIN_BITS-1:0] win_data,
    output logic                win_valid,
    input  logic                win_ready,
    output logic [7:0]          win_row,
`ifdef STALL_CNT_EN
    output logic [15:0]         stall_cnt,
`endif
    output logic [7:0]          win_col
);

    state_e                state_q, state_d;
    logic                  clear, issue, advance, last_elem, last_win;
    logic [3:0]            elem;
    logic [ADDR_W-1:0]     addr;
    logic [7:0]            row, col;
    logic                  cap_en_q;
    logic [3:0]            cap_idx_q;
    logic [WIN_BITS-1:0]   win_data_q, win_data_d;

    pool_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (clear),
        .issue_i     (issue),
        .advance_i   (advance),
        .elem_o      (elem),
        .row_o       (row),
        .col_o       (col),
        .addr_o      (addr),
        .last_elem_o (last_elem),
        .last_win_o  (last_win)
    );

    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        issue   = 1'b0;
        advance = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    clear   = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                issue = 1'b1;
                if (last_elem) state_d = CAPTURE;
            end
            CAPTURE: state_d = PRESENT;
            PRESENT: begin
                if (win_ready) begin
                    advance = 1'b1;
                    state_d = last_win ? DONE : FETCH;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read data lands one edge after the address, so the slot index is delayed too.
    always_comb begin
        win_data_d = win_data_q;
        if (cap_en_q) begin
            win_data_d[int'(cap_idx_q)*PIX_W +: PIX_W] = PIX_W'(bram_dout);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cap_en_q   <= 1'b0;
            cap_idx_q  <= '0;
            win_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cap_en_q   <= issue;
            cap_idx_q  <= elem;
            win_data_q <= win_data_d;
        end
    end

`ifdef STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (clear) begin
            stall_d = '0;
        end else if (state_q == PRESENT && !win_ready && stall_q != '1) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_q <= '0;
        else        stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;
`endif

    assign busy      = (state_q == FETCH) || (state_q == CAPTURE) || (state_q == PRESENT);
    assign done      = (state_q == DONE);
    assign bram_en   = issue;
    assign bram_addr = issue ? addr : '0;
    assign win_valid = (state_q == PRESENT);
    assign win_data  = win_data_q;
    assign win_row   = row;
    assign win_col   = col;

endmodule
